// File: rtl/rom_loader_pkg.sv
// Shared types for the ROM download path.
//   writer_state_t : SDRAM writer FSM states
//   sdram_word_t   : one buffered SDRAM write (word index + 32-bit data)
//   LANES          : bytes per SDRAM word
//   lane_fill      : zero every byte lane whose mask bit is clear
package rom_loader_pkg;

  typedef enum logic {IDLE, REQ} writer_state_t;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } sdram_word_t;

  localparam int LANES = 4;

  function automatic logic [31:0] lane_fill(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/rom_download_writer_word_fifo.sv
// word_fifo: synchronous FIFO of sdram_word_t that accepts up to two writes
// per cycle (port a is written first, port b lands in the following slot).
//   clk, reset      : clock, asynchronous active-high reset (pointers/count only)
//   push_a, din_a   : first write
//   push_b, din_b   : second write
//   pop             : drop the head entry
//   head            : oldest entry
//   count/full/empty: occupancy
// The caller guarantees pushes never exceed free space and pop never hits empty.
module word_fifo
  import rom_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push_a,
  input  sdram_word_t                     din_a,
  input  logic                            push_b,
  input  sdram_word_t                     din_b,
  input  logic                            pop,
  output sdram_word_t                     head,
  output logic [$clog2(FIFO_DEPTH):0]     count,
  output logic                            full,
  output logic                            empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  sdram_word_t   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr_b;

  assign wptr_b = wptr + PW'(push_a);

  // Storage is data only; no reset needed.
  always_ff @(posedge clk) begin
    if (push_a) mem[wptr]   <= din_a;
    if (push_b) mem[wptr_b] <= din_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(push_a) + PW'(push_b);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rom_download_writer.sv
// rom_download_writer: packs HPS ioctl download bytes into little-endian
// 32-bit words, buffers them in word_fifo and writes them to SDRAM over a
// req/ack handshake. rom_ready reports that a download has fully landed.
//   clk, reset             : system clock, asynchronous active-high reset
//   ioctl_addr/data/wr     : byte download strobe (ignored while ioctl_download low)
//   ioctl_download         : high for the whole download
//   ioctl_wait             : back-pressure, high while <=1 FIFO entry is free
//   sdram_addr/data/we/req : write request, held stable until sdram_ack
//   sdram_ack              : one-cycle accept
//   rom_ready              : download complete and drained
//   overflow               : sticky, a byte/word was dropped for lack of space
//   checksum               : 16-bit additive byte sum
// Optional feature macro: ROM_CHECKSUM_EN (when undefined checksum is 0).
module rom_download_writer
  import rom_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SDRAM_AW   = 23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  input  logic                ioctl_download,
  output logic                ioctl_wait,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic [31:0]         sdram_data,
  output logic                sdram_we,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic                rom_ready,
  output logic                overflow,
  output logic [15:0]         checksum
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          dl_q;
  logic [22:0]   pk_idx;
  logic [3:0]    pk_mask;
  logic [31:0]   pk_data;
  writer_state_t state;
  logic          armed;

  logic          strobe, rise, fall;
  logic [3:0]    cur_mask, mask_nx;
  logic [22:0]   new_idx;
  logic [1:0]    lane;
  logic [31:0]   data_nx;
  logic          flush_strobe, need_flush, complete;
  logic          push_a, push_b, pop, lost, more;
  logic [CW-1:0] free;
  sdram_word_t   word_a, word_b, head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  always_comb begin
    strobe   = ioctl_wr & ioctl_download;
    rise     = ioctl_download & ~dl_q;
    fall     = ~ioctl_download & dl_q;
    // A rising download edge discards whatever the packer held.
    cur_mask = rise ? 4'b0000 : pk_mask;
    new_idx  = ioctl_addr[24:2];
    lane     = ioctl_addr[1:0];

    flush_strobe = strobe && (cur_mask != 4'b0000) && (new_idx != pk_idx);
    need_flush   = flush_strobe || (fall && (pk_mask != 4'b0000));
    complete     = strobe && (lane == 2'd3);

    data_nx = pk_data;
    for (int i = 0; i < LANES; i++)
      if (lane == 2'(i)) data_nx[8*i +: 8] = ioctl_data;
    mask_nx = (flush_strobe ? 4'b0000 : cur_mask) | (4'b0001 << lane);

    word_a = {pk_idx, lane_fill(pk_data, pk_mask)};
    word_b = {new_idx, lane_fill(data_nx, mask_nx)};

    // The flush word goes first; the completing word needs one more free slot.
    free   = CW'(FIFO_DEPTH) - fifo_count;
    push_a = need_flush && !fifo_full;
    push_b = complete && (free > CW'(push_a));
    lost   = (need_flush && !push_a) || (complete && !push_b);

    pop  = (state == REQ) && sdram_ack;
    more = (fifo_count > CW'(1)) || push_a || push_b;
  end

  assign ioctl_wait = ioctl_download && (free <= CW'(1));
  assign sdram_req  = (state == REQ);
  assign sdram_we   = sdram_req;
  assign sdram_addr = sdram_req ? head.addr[SDRAM_AW-1:0] : '0;
  assign sdram_data = sdram_req ? head.data : 32'h0;

  word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_a (push_a),
    .din_a  (word_a),
    .push_b (push_b),
    .din_b  (word_b),
    .pop    (pop),
    .head   (head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (strobe) pk_data <= data_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_q      <= 1'b0;
      pk_idx    <= '0;
      pk_mask   <= 4'b0000;
      state     <= IDLE;
      armed     <= 1'b0;
      rom_ready <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      dl_q <= ioctl_download;

      if (strobe) begin
        pk_idx  <= new_idx;
        pk_mask <= complete ? 4'b0000 : mask_nx;
      end else if (rise || fall) begin
        pk_mask <= 4'b0000;
      end

      if (lost) overflow <= 1'b1;

      // Entering REQ on the push cycle gives req the cycle after the last byte.
      case (state)
        IDLE: if (!fifo_empty || push_a || push_b) state <= REQ;
        REQ:  if (sdram_ack && !more) state <= IDLE;
        default: state <= IDLE;
      endcase

      // armed keeps rom_ready low after reset until a download has been seen.
      if (rise) begin
        rom_ready <= 1'b0;
        armed     <= 1'b1;
      end else if (armed && !ioctl_download && (pk_mask == 4'b0000) &&
                   fifo_empty && (state == IDLE)) begin
        rom_ready <= 1'b1;
        armed     <= 1'b0;
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic        byte_ok;
  logic [15:0] sum;

  // A byte whose completing word is dropped does not count.
  assign byte_ok = strobe && !(complete && !push_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= 16'h0000;
    end else if (rise) begin
      sum <= byte_ok ? {8'h00, ioctl_data} : 16'h0000;
    end else if (byte_ok && !rom_ready) begin
      sum <= sum + {8'h00, ioctl_data};
    end
  end

  assign checksum = sum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_download_writer.sv
module tb_rom_download_writer;

  typedef struct packed {
    logic [22:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        ioctl_download;
  logic        ioctl_wait;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic        rom_ready;
  logic        overflow;
  logic [15:0] checksum;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   ack_en = 0;

`ifdef ROM_CHECKSUM_EN
  localparam logic [15:0] SUM2 = 16'h001C;
  localparam logic [15:0] SUM6 = 16'h0200;
`else
  localparam logic [15:0] SUM2 = 16'h0000;
  localparam logic [15:0] SUM6 = 16'h0000;
`endif

  rom_download_writer dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wr       (ioctl_wr),
    .ioctl_download (ioctl_download),
    .ioctl_wait     (ioctl_wait),
    .sdram_addr     (sdram_addr),
    .sdram_data     (sdram_data),
    .sdram_we       (sdram_we),
    .sdram_req      (sdram_req),
    .sdram_ack      (sdram_ack),
    .rom_ready      (rom_ready),
    .overflow       (overflow),
    .checksum       (checksum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Controller model: ack one cycle after req is seen, one-cycle pulse.
  initial begin
    sdram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = ack_en && sdram_req && !sdram_ack;
    end
  end

  // Monitor: every accepted write is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && sdram_req && sdram_ack) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: got addr %0h data %0h required no write",
                   sdram_addr, sdram_data);
        end else begin
          check("write", {8'h00, sdram_we, sdram_addr, sdram_data},
                {8'h00, 1'b1, sb[0].addr, sb[0].data});
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [24:0] a, input logic [7:0] d, input bit honor);
    int n;
    n = 0;
    if (honor) begin
      while (ioctl_wait && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) begin
        checks++;
        errors++;
        $display("FAIL wait_timeout: got ioctl_wait 1 for %0d cycles required release", n);
      end
    end
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rom_ready && n < 300) begin
      tick();
      n++;
    end
    check("rom_ready", 64'(rom_ready), 64'd1);
    check("drained_at_ready", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 64'(sdram_req), 64'd0);
    check("rst_we", 64'(sdram_we), 64'd0);
    check("rst_addr_data", {9'h0, sdram_addr, sdram_data}, 64'd0);
    check("rst_ready", 64'(rom_ready), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_wait_checksum", {47'h0, ioctl_wait, checksum}, 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_ready_low", 64'(rom_ready), 64'd0);

    // 1: single full word, one-cycle req latency
    ack_en = 1'b1;
    start_dl();
    sb.push_back('{addr: 23'h0, data: 32'h44332211});
    put_byte(25'h0, 8'h11, 1'b1);
    put_byte(25'h1, 8'h22, 1'b1);
    put_byte(25'h2, 8'h33, 1'b1);
    put_byte(25'h3, 8'h44, 1'b1);
    check("req_latency", 64'(sdram_req), 64'd1);
    end_dl();
    wait_ready();

    // 2: seven bytes, partial word flushed when download falls
    start_dl();
    check("ready_clear_on_rise", 64'(rom_ready), 64'd0);
    sb.push_back('{addr: 23'h40, data: 32'h04030201});
    sb.push_back('{addr: 23'h41, data: 32'h00070605});
    for (int i = 0; i < 7; i++) put_byte(25'h100 + 25'(i), 8'(i + 1), 1'b1);
    end_dl();
    wait_ready();
    check("checksum_t2", 64'(checksum), 64'(SUM2));

    // 3: ack withheld, back-pressure at one free entry
    ack_en = 1'b0;
    start_dl();
    for (int w = 0; w < 4; w++)
      sb.push_back('{addr: 23'h100 + 23'(w),
                     data: {8'(4*w + 8'h13), 8'(4*w + 8'h12), 8'(4*w + 8'h11), 8'(4*w + 8'h10)}});
    for (int i = 0; i < 8; i++) put_byte(25'h400 + 25'(i), 8'(i + 8'h10), 1'b1);
    check("wait_two_free", 64'(ioctl_wait), 64'd0);
    for (int i = 8; i < 12; i++) put_byte(25'h400 + 25'(i), 8'(i + 8'h10), 1'b1);
    check("wait_one_free", 64'(ioctl_wait), 64'd1);
    repeat (28) tick();
    check("no_overflow_t3", 64'(overflow), 64'd0);
    ack_en = 1'b1;
    for (int i = 12; i < 16; i++) put_byte(25'h400 + 25'(i), 8'(i + 8'h10), 1'b1);
    end_dl();
    wait_ready();
    check("no_overflow_t3_end", 64'(overflow), 64'd0);

    // 4: back-pressure ignored; words 4 and 5 are lost
    ack_en = 1'b0;
    start_dl();
    for (int w = 0; w < 4; w++)
      sb.push_back('{addr: 23'h80 + 23'(w),
                     data: {8'(4*w + 8'h43), 8'(4*w + 8'h42), 8'(4*w + 8'h41), 8'(4*w + 8'h40)}});
    for (int i = 0; i < 24; i++) put_byte(25'h200 + 25'(i), 8'(i + 8'h40), 1'b0);
    check("overflow_set", 64'(overflow), 64'd1);
    ack_en = 1'b1;
    end_dl();
    wait_ready();
    start_dl();
    tick();
    check("overflow_sticky", 64'(overflow), 64'd1);
    end_dl();
    wait_ready();

    // 5: reset while a request is outstanding
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 4; i++) put_byte(25'h800 + 25'(i), 8'(i + 8'hA0), 1'b1);
    tick();
    check("req_before_reset", 64'(sdram_req), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("req_async_drop", 64'(sdram_req), 64'd0);
    check("fifo_empty_in_reset", 64'(dut.fifo_empty), 64'd1);
    check("ready_in_reset", 64'(rom_ready), 64'd0);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("overflow_cleared", 64'(overflow), 64'd0);
    check("req_after_reset", 64'(sdram_req), 64'd0);

    // 6: checksum with wrap-free carry into the high byte
    ack_en = 1'b1;
    start_dl();
    sb.push_back('{addr: 23'h0, data: 32'h0002FFFF});
    put_byte(25'h0, 8'hFF, 1'b1);
    put_byte(25'h1, 8'hFF, 1'b1);
    put_byte(25'h2, 8'h02, 1'b1);
    end_dl();
    wait_ready();
    check("checksum_t6", 64'(checksum), 64'(SUM6));
    repeat (3) tick();
    check("checksum_frozen", 64'(checksum), 64'(SUM6));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
